// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if
//   Bundles the decode-issue, writeback and status signals of the register
//   file hazard scoreboard.
//   master : decode/writeback side. Drives dec_*, wb_* and flush.
//            Receives issue_ready, stall, busy_mask, outstanding and underflow_err.
//   slave  : the scoreboard itself (regfile_scoreboard).
interface regfile_scoreboard_if #(
  parameter int ADDR  = 5,
  parameter int NREGS = 32,
  parameter int TOT_W = 7
) ();

  // Decode issue request
  logic             dec_valid;
  logic [ADDR-1:0]  dec_rs1_addr;
  logic             dec_rs1_used;
  logic [ADDR-1:0]  dec_rs2_addr;
  logic             dec_rs2_used;
  logic [ADDR-1:0]  dec_rd_addr;
  logic             dec_rd_we;
  logic             issue_ready;
  logic             stall;

  // Writeback and pipeline control
  logic             wb_write_en;
  logic [ADDR-1:0]  wb_rd_addr;
  logic             flush;

  // Status
  logic [NREGS-1:0] busy_mask;
  logic [TOT_W-1:0] outstanding;
  logic             underflow_err;

  modport master (
    output dec_valid, dec_rs1_addr, dec_rs1_used, dec_rs2_addr, dec_rs2_used,
    output dec_rd_addr, dec_rd_we, wb_write_en, wb_rd_addr, flush,
    input  issue_ready, stall, busy_mask, outstanding, underflow_err
  );

  modport slave (
    input  dec_valid, dec_rs1_addr, dec_rs1_used, dec_rs2_addr, dec_rs2_used,
    input  dec_rd_addr, dec_rd_we, wb_write_en, wb_rd_addr, flush,
    output issue_ready, stall, busy_mask, outstanding, underflow_err
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Tracks in-flight writes per architectural register using a small
//   saturating counter. Decode is held off on read-after-write hazards and
//   when a destination counter is already full. Register data is never seen
//   here; the block only sequences register-file port usage.
// Ports:
//   clk    : rising-edge clock for all state
//   rst_n  : asynchronous active-low reset
//   sb     : regfile_scoreboard_if.slave. It carries the decode request,
//            issue_ready/stall, the writeback request, flush and the
//            registered status outputs (busy_mask, outstanding, underflow_err).
module regfile_scoreboard #(
  parameter int ADDR  = 5,
  parameter int NREGS = 32,
  parameter int CNT_W = 2,
  parameter int TOT_W = 7
) (
  input logic               clk,
  input logic               rst_n,
  regfile_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CMAX     = {CNT_W{1'b1}};
  localparam logic [ADDR-1:0]  ADDR_ZERO = {ADDR{1'b0}};
  localparam logic [NREGS-1:0] ONEHOT_1  = {{(NREGS-1){1'b0}}, 1'b1};
  localparam logic [NREGS-1:0] MASK_ZERO = {NREGS{1'b0}};
  localparam logic [TOT_W-1:0] TOT_ZERO  = {TOT_W{1'b0}};

  // Entry 0 exists only so that indexing with address 0 is well defined.
  // It is never written with anything other than zero.
  logic [CNT_W-1:0] cnt_r     [NREGS];
  logic [CNT_W-1:0] cnt_nxt_s [NREGS];

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [TOT_W-1:0] outstanding_r;
  logic [TOT_W-1:0] outstanding_nxt_s;
  logic             underflow_r;
  logic             underflow_nxt_s;

  logic [CNT_W-1:0] rs1_cnt_s;
  logic [CNT_W-1:0] rs2_cnt_s;
  logic [CNT_W-1:0] rd_cnt_s;
  logic [CNT_W-1:0] wb_cnt_s;

  logic             raw1_s;
  logic             raw2_s;
  logic             waw_s;
  logic             issue_ready_s;
  logic             inc_s;
  logic             wb_req_s;
  logic             same_reg_s;
  logic             dec_eff_s;
  logic             underflow_hit_s;
  logic [NREGS-1:0] inc_onehot_s;
  logic [NREGS-1:0] dec_onehot_s;

  // Hazard detection and per-cycle increment/decrement qualification
  always_comb begin
    rs1_cnt_s = cnt_r[sb.dec_rs1_addr];
    rs2_cnt_s = cnt_r[sb.dec_rs2_addr];
    rd_cnt_s  = cnt_r[sb.dec_rd_addr];
    wb_cnt_s  = cnt_r[sb.wb_rd_addr];

    // A source with a pending write stalls even when writeback targets it
    // this very cycle: the register file write only lands on the edge.
    raw1_s = sb.dec_rs1_used & (sb.dec_rs1_addr != ADDR_ZERO) & (rs1_cnt_s != CNT_ZERO);
    raw2_s = sb.dec_rs2_used & (sb.dec_rs2_addr != ADDR_ZERO) & (rs2_cnt_s != CNT_ZERO);
    waw_s  = sb.dec_rd_we & (sb.dec_rd_addr != ADDR_ZERO) & (rd_cnt_s == CMAX);

    // Flush also forces issue_ready low, so no increment can happen in a flush cycle.
    issue_ready_s = ~raw1_s & ~raw2_s & ~waw_s & ~sb.flush;

    inc_s    = sb.dec_valid & issue_ready_s & sb.dec_rd_we & (sb.dec_rd_addr != ADDR_ZERO);
    wb_req_s = sb.wb_write_en & (sb.wb_rd_addr != ADDR_ZERO) & ~sb.flush;

    // Issue and writeback to the same register cancel. From a zero count this
    // is a legal pairing and does not count as underflow.
    same_reg_s      = inc_s & wb_req_s & (sb.dec_rd_addr == sb.wb_rd_addr);
    dec_eff_s       = wb_req_s & ((wb_cnt_s != CNT_ZERO) | same_reg_s);
    underflow_hit_s = wb_req_s & (wb_cnt_s == CNT_ZERO) & ~same_reg_s;

    if (inc_s) begin
      inc_onehot_s = ONEHOT_1 << sb.dec_rd_addr;
    end else begin
      inc_onehot_s = MASK_ZERO;
    end

    if (dec_eff_s) begin
      dec_onehot_s = ONEHOT_1 << sb.wb_rd_addr;
    end else begin
      dec_onehot_s = MASK_ZERO;
    end
  end

  // Next-state for counters, busy mask, total and sticky underflow
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (sb.flush || (i == 0)) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (inc_onehot_s[i] && !dec_onehot_s[i]) begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end else if (dec_onehot_s[i] && !inc_onehot_s[i]) begin
        cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
      busy_nxt_s[i] = (cnt_nxt_s[i] != CNT_ZERO);
    end

    if (sb.flush) begin
      outstanding_nxt_s = TOT_ZERO;
    end else begin
      outstanding_nxt_s = outstanding_r + TOT_W'(inc_s) - TOT_W'(dec_eff_s);
    end

    underflow_nxt_s = underflow_r | underflow_hit_s;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      busy_r        <= MASK_ZERO;
      outstanding_r <= TOT_ZERO;
      underflow_r   <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      busy_r        <= busy_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      underflow_r   <= underflow_nxt_s;
    end
  end

  assign sb.issue_ready   = issue_ready_s;
  assign sb.stall         = sb.dec_valid & ~issue_ready_s;
  assign sb.busy_mask     = busy_r;
  assign sb.outstanding   = outstanding_r;
  assign sb.underflow_err = underflow_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: directed scenarios followed by random
// traffic, all compared against a count-per-register reference model.
module tb_regfile_scoreboard;

  localparam int ADDR  = 5;
  localparam int NREGS = 32;
  localparam int CNT_W = 2;
  localparam int TOT_W = 7;
  localparam int CMAX  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.ADDR(ADDR), .NREGS(NREGS), .TOT_W(TOT_W)) bus ();

  regfile_scoreboard #(.ADDR(ADDR), .NREGS(NREGS), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer count per register plus sticky flag
  int m_cnt [NREGS];
  bit m_uf;
  logic last_ready;
  logic last_stall;

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
    m_uf = 1'b0;
  endfunction

  function automatic logic [NREGS-1:0] exp_busy();
    logic [NREGS-1:0] b;
    b = '0;
    for (int i = 0; i < NREGS; i++) b[i] = (m_cnt[i] > 0);
    return b;
  endfunction

  function automatic int exp_total();
    int s;
    s = 0;
    for (int i = 0; i < NREGS; i++) s += m_cnt[i];
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus. Entered and left at posedge+1.
  task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit we, input bit wbe, input int wba, input bit fl);
    bit ready;
    bit inc;
    bus.dec_valid    = v;
    bus.dec_rs1_addr = rs1[ADDR-1:0];
    bus.dec_rs1_used = u1;
    bus.dec_rs2_addr = rs2[ADDR-1:0];
    bus.dec_rs2_used = u2;
    bus.dec_rd_addr  = rd[ADDR-1:0];
    bus.dec_rd_we    = we;
    bus.wb_write_en  = wbe;
    bus.wb_rd_addr   = wba[ADDR-1:0];
    bus.flush        = fl;
    #1;
    ready = !(u1 && rs1 != 0 && m_cnt[rs1] != 0) &&
            !(u2 && rs2 != 0 && m_cnt[rs2] != 0) &&
            !(we && rd != 0 && m_cnt[rd] == CMAX) && !fl;
    last_ready = bus.issue_ready;
    last_stall = bus.stall;
    check("issue_ready", {63'd0, bus.issue_ready}, {63'd0, ready});
    check("stall", {63'd0, bus.stall}, {63'd0, (v && !ready)});
    if (fl) begin
      for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
    end else begin
      inc = v && ready && we && rd != 0;
      if (inc) m_cnt[rd] = m_cnt[rd] + 1;
      if (wbe && wba != 0) begin
        if (m_cnt[wba] > 0) m_cnt[wba] = m_cnt[wba] - 1;
        else m_uf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("busy_mask", {32'd0, bus.busy_mask}, {32'd0, exp_busy()});
    check("outstanding", {57'd0, bus.outstanding}, 64'(exp_total()));
    check("underflow_err", {63'd0, bus.underflow_err}, {63'd0, m_uf});
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_busy", {32'd0, bus.busy_mask}, 64'd0);
    check("rst_outstanding", {57'd0, bus.outstanding}, 64'd0);
    check("rst_underflow", {63'd0, bus.underflow_err}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.dec_valid = 1'b0; bus.dec_rs1_addr = '0; bus.dec_rs1_used = 1'b0;
    bus.dec_rs2_addr = '0; bus.dec_rs2_used = 1'b0; bus.dec_rd_addr = '0;
    bus.dec_rd_we = 1'b0; bus.wb_write_en = 1'b0; bus.wb_rd_addr = '0; bus.flush = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_busy", {32'd0, bus.busy_mask}, 64'd0);
    check("reset_outstanding", {57'd0, bus.outstanding}, 64'd0);
    check("reset_underflow", {63'd0, bus.underflow_err}, 64'd0);
    check("reset_ready", {63'd0, bus.issue_ready}, 64'd1);
    rst_n = 1'b1;

    // RAW on register 5, with no same-cycle bypass
    step(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 0, 1'b0);
    check("t1_issue_ready", {63'd0, last_ready}, 64'd1);
    check("t1_busy5", {63'd0, bus.busy_mask[5]}, 64'd1);
    step(1'b1, 5, 1'b1, 0, 1'b0, 6, 1'b0, 1'b0, 0, 1'b0);
    check("t1_raw_stall", {63'd0, last_stall}, 64'd1);
    step(1'b1, 5, 1'b1, 0, 1'b0, 6, 1'b0, 1'b1, 5, 1'b0);
    check("t1_no_bypass", {63'd0, last_stall}, 64'd1);
    step(1'b1, 5, 1'b1, 0, 1'b0, 6, 1'b0, 1'b0, 0, 1'b0);
    check("t1_released", {63'd0, last_stall}, 64'd0);
    check("t1_outstanding0", {57'd0, bus.outstanding}, 64'd0);

    // Saturation on register 7
    repeat (3) step(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0, 0, 1'b0);
    check("t2_out3", {57'd0, bus.outstanding}, 64'd3);
    step(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b1, 7, 1'b0);
    check("t2_waw_stall", {63'd0, last_stall}, 64'd1);
    step(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0, 0, 1'b0);
    check("t2_fourth_issues", {63'd0, last_ready}, 64'd1);
    repeat (3) step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 7, 1'b0);

    // Same-cycle issue and writeback on register 9
    step(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b1, 9, 1'b0);
    check("t3_out1", {57'd0, bus.outstanding}, 64'd1);
    check("t3_no_uf", {63'd0, bus.underflow_err}, 64'd0);
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 9, 1'b0);

    // x0 everywhere
    step(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0);
    check("t4_ready", {63'd0, last_ready}, 64'd1);
    check("t4_busy0", {32'd0, bus.busy_mask}, 64'd0);

    // Underflow on register 12, sticky
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 12, 1'b0);
    check("t5_uf", {63'd0, bus.underflow_err}, 64'd1);
    idle();
    check("t5_uf_sticky", {63'd0, bus.underflow_err}, 64'd1);

    // Flush discards same-cycle issue/writeback
    step(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 0, 1'b0, 0, 1'b0, 8, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 0, 1'b0, 0, 1'b0, 20, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b1, 3, 1'b1);
    check("t6_flush_ready", {63'd0, last_ready}, 64'd0);
    check("t6_flush_busy", {32'd0, bus.busy_mask}, 64'd0);
    check("t6_flush_out", {57'd0, bus.outstanding}, 64'd0);

    // Mid-stream asynchronous reset
    step(1'b1, 0, 1'b0, 0, 1'b0, 11, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 0, 1'b0, 0, 1'b0, 11, 1'b1, 1'b1, 13, 1'b0);
    async_reset();

    // Random traffic focused on a few registers to provoke hazards
    for (int n = 0; n < 600; n++) begin
      int lim;
      lim = ($urandom_range(0, 7) == 0) ? 31 : 7;
      if (n == 300) async_reset();
      step(1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, lim)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, lim)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, lim)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), int'($urandom_range(0, lim)),
           1'($urandom_range(0, 40) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Register-file hazard scoreboard sitting between the decode stage and the register file's write port. It keeps a small in-flight write counter for every architectural register: decode issues an instruction, the counter for its destination is raised, and the matching writeback lowers it again. Decode is stalled while any source operand has an outstanding write (RAW), or while the destination counter is saturated (WAW overflow). The block only sequences access to the register file's read/write ports and never touches register data.

## Interface
Parameters:
- ADDR, 5, register address width
- NREGS, 32, number of architectural registers (2**ADDR)
- CNT_W, 2, per-register counter width; maximum outstanding writes per register is CMAX = 2**CNT_W-1
- TOT_W, 7, width of the total-outstanding count; must hold NREGS*CMAX

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- dec_valid  in  1  decode presents an instruction for issue
- dec_rs1_addr  in  ADDR  source 1 register
- dec_rs1_used  in  1  instruction reads rs1
- dec_rs2_addr  in  ADDR  source 2 register
- dec_rs2_used  in  1  instruction reads rs2
- dec_rd_addr  in  ADDR  destination register
- dec_rd_we  in  1  instruction writes rd
- issue_ready  out  1  combinational: instruction may issue this cycle
- stall  out  1  combinational: dec_valid & ~issue_ready
- wb_write_en  in  1  writeback stage writes the register file this cycle
- wb_rd_addr  in  ADDR  writeback destination
- flush  in  1  pipeline squash; clears all tracking
- busy_mask  out  NREGS  registered; bit i = (cnt[i] != 0)
- outstanding  out  TOT_W  registered sum of all counters
- underflow_err  out  1  sticky: a writeback arrived for a register whose count was 0

## Operation
- State: cnt[i], CNT_W bits each, i = 1..NREGS-1. cnt[0] does not exist and reads as 0.
- x0 is ignored everywhere. rs=0 never causes a hazard. rd=0 or wb_rd_addr=0 never changes any counter.
- raw1 = dec_rs1_used & cnt[rs1] != 0. raw2 is defined the same way for rs2.
- waw = dec_rd_we & rd != 0 & cnt[rd] == CMAX.
- issue_ready = ~raw1 & ~raw2 & ~waw & ~flush. It does not depend on dec_valid.
- A same-cycle writeback is not bypassed. A source with cnt != 0 stalls even if wb_write_en targets it in that cycle, because the register file write is synchronous.
- inc = dec_valid & issue_ready & dec_rd_we & rd != 0. It adds 1 to cnt[rd].
- dec = wb_write_en & wb_rd_addr != 0. It subtracts 1 from cnt[wb_rd_addr] if that count is > 0. If the count is 0, the counter holds at 0 and underflow_err is set.
- inc and dec on the same register in the same cycle give a net change of 0. This holds at 0 (no underflow flagged) and at CMAX (inc is already blocked by waw).
- Counters never wrap. The waw check prevents overflow, and dec saturates at 0.
- flush: on the edge, all cnt are cleared to 0. inc and dec for that cycle are discarded and underflow_err is not set. issue_ready is forced low during the flush cycle.
- outstanding is updated on the same edge as the counters: previous value + inc - (effective dec).
- underflow_err is cleared only by reset.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream):
  - all cnt = 0
  - busy_mask = 0
  - outstanding = 0
  - underflow_err = 0
  - issue_ready = 1 when ~flush and no sources are in use
- Issue latency: the counter raised on edge N is visible in busy_mask and in the hazard check from cycle N+1.
- Writeback latency: the counter lowered on edge N releases a dependent instruction in cycle N+1.
- Reset asserted mid-operation clears all state immediately, with no dependence on clk.

## Test plan
- Reset, then issue rd=5 (dec_valid=1, rd_we=1) → issue_ready=1; next cycle busy_mask[5]=1 and outstanding=1. An instruction with rs1=5 then sees stall=1 until wb_rd_addr=5 is applied. After that, stall=0 in the following cycle and outstanding=0.
- Issue rd=7 three times back-to-back → cnt[7]=3. A fourth issue with rd=7 gives issue_ready=0 and stall=1. Applying one writeback to 7 → cnt[7]=2 and the fourth issue proceeds.
- Same cycle: issue rd=9 (cnt[9]=1) together with writeback to 9 → cnt[9] stays 1, outstanding is unchanged, underflow_err=0.
- Instruction with rs1=0, rs2=0, rd=0 and writeback to 0 → issue_ready=1 and busy_mask/outstanding remain 0.
- Writeback to register 12 with cnt[12]=0 → underflow_err=1 and stays 1; cnt[12]=0.
- Set counts 3, 8 and 20 to nonzero values, then assert flush while issuing rd=4 and writing back 3 → issue_ready=0 in that cycle. Next cycle busy_mask=0 and outstanding=0. Asserting rst_n=0 mid-stream clears all outputs immediately.
